param_reg_file: RTL
===================

// Module: param_reg_file
// PURPOSE
//  Parametrised general-purpose register file for the datapath: NREG registers of WIDTH bits.
//  Each register supports per-cycle decrement, increment, load, clear, half-word loads and hold.
//  Provides two independent combinational read ports (A, B) feeding the ALU operand muxes.
//  Registered wrap/zero status lets the control unit sequence loop counters without an ALU pass.
// PARAMETERS
//  WIDTH      8     register width in bits; must be even and >= 2
//  NREG       4     number of registers; 2..16
//  SELW       2     read-select width; must be >= clog2(NREG)
//  RESET_VAL  0     value loaded into every register on reset
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous reset, active-low
//  FunSel     in   3          operation applied to every enabled register
//  RegSel     in   NREG       per-register enable, active-low (bit i = 0 enables Ri)
//  I          in   WIDTH      write data
//  OutASel    in   SELW       read port A register index
//  OutBSel    in   SELW       read port B register index
//  OutA       out  WIDTH      contents of R[OutASel]
//  OutB       out  WIDTH      contents of R[OutBSel]
//  ZeroFlag   out  NREG       bit i = 1 when R[i] == 0
//  WrapPulse  out  NREG       bit i = 1 for one cycle after an inc/dec on R[i] wrapped
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. All state updates on rising clk only.
//  - Reset (rst_n=0 at edge): every R[i] <= RESET_VAL, WrapPulse <= 0; overrides all ops.
//    ZeroFlag follows reset contents (all 1 when RESET_VAL==0). Reset mid-sequence discards op.
//  - FunSel, applied at the edge to each R[i] with RegSel[i]==0 (others hold):
//    000 dec: R <= R-1 mod 2^WIDTH     001 inc: R <= R+1 mod 2^WIDTH
//    010 load: R <= I                  011 clear: R <= 0
//    100 load low: R[WIDTH/2-1:0] <= I[WIDTH/2-1:0], upper half held
//    101 load high: R[WIDTH-1:WIDTH/2] <= I[WIDTH/2-1:0], lower half held
//    110, 111: hold (reserved; no state change, no wrap pulse)
//  - Multiple enabled registers execute the same op simultaneously, each on its own value.
//  - RegSel all ones: no register changes regardless of FunSel.
//  - Wrap: WrapPulse[i] <= 1 at the edge where enabled inc takes R[i] from 2^WIDTH-1 to 0, or
//    enabled dec takes R[i] from 0 to 2^WIDTH-1; else WrapPulse[i] <= 0. Pulse width one cycle,
//    re-asserts every wrapping cycle.
//  - Reads: OutA/OutB combinational from current register contents (pre-edge value; no
//    write-through bypass). Write at edge is visible on OutA/OutB after that edge.
//  - OutASel/OutBSel >= NREG: port outputs 0. A and B may select the same register.
//  - ZeroFlag combinational from register contents; no latency beyond register update.
//  - No X propagation: every output defined from the first reset onward.
// TESTING
//  1 Reset: rst_n=0 one cycle, RESET_VAL=0 -> all R=0, ZeroFlag=4'b1111, WrapPulse=0, OutA=OutB=0.
//  2 Load/read: FunSel=010, RegSel=4'b1101, I=8'hA5 -> R1=8'hA5; OutASel=1,OutBSel=1 -> both 8'hA5;
//    ZeroFlag[1]=0; other registers unchanged.
//  3 Wrap: load R2=8'hFF, then inc RegSel=4'b1011 -> R2=0, WrapPulse=4'b0100 for exactly one cycle;
//    dec on R2=0 -> R2=8'hFF, WrapPulse[2]=1 one cycle.
//  4 Half loads: R3=8'h00; FunSel=100,I=8'h3C -> R3=8'h0C; FunSel=101,I=8'h07 -> R3=8'h7C.
//  5 Multi-enable + hold: R0=1,R1=5; inc with RegSel=4'b1100 -> R0=2,R1=6; FunSel=110 any RegSel
//    -> no change, WrapPulse=0; out-of-range select (NREG=3, OutASel=3) -> OutA=0.
//  6 Reset priority: rst_n=0 with FunSel=010,RegSel=0,I=8'h55 -> all R=RESET_VAL, no load.

Source files
------------

// File: rtl/param_reg_file.sv
// Parametrised general-purpose register file with inc/dec/load/half-load ops.
// Two combinational read ports plus registered wrap pulses and zero flags.
module param_reg_file #(
    parameter int              WIDTH     = 8,
    parameter int              NREG      = 4,
    parameter int              SELW      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       FunSel,
    input  logic [NREG-1:0]  RegSel,
    input  logic [WIDTH-1:0] I,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [NREG-1:0]  ZeroFlag,
    output logic [NREG-1:0]  WrapPulse
);

    localparam int H = WIDTH / 2;

    localparam logic [2:0] OP_DEC  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_LDLO = 3'b100;
    localparam logic [2:0] OP_LDHI = 3'b101;

    localparam logic [WIDTH-1:0] ALL1 = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    generate
        if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
            $error("param_reg_file: WIDTH must be even and >= 2");
        end
        if ((NREG < 2) || (NREG > 16)) begin : g_bad_nreg
            $error("param_reg_file: NREG must be in 2..16");
        end
        if ((1 << SELW) < NREG) begin : g_bad_selw
            $error("param_reg_file: SELW too narrow for NREG");
        end
    endgenerate

    logic [WIDTH-1:0] r_q [NREG];
    logic [WIDTH-1:0] r_d [NREG];
    logic [NREG-1:0]  wrap_q;
    logic [NREG-1:0]  wrap_d;

    // Next-state for every register: enabled ones apply FunSel, others hold.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            r_d[i]    = r_q[i];
            wrap_d[i] = 1'b0;
            if (!RegSel[i]) begin
                case (FunSel)
                    OP_DEC: begin
                        r_d[i]    = r_q[i] - ONE;
                        wrap_d[i] = (r_q[i] == '0);
                    end
                    OP_INC: begin
                        r_d[i]    = r_q[i] + ONE;
                        wrap_d[i] = (r_q[i] == ALL1);
                    end
                    OP_LD:   r_d[i] = I;
                    OP_CLR:  r_d[i] = '0;
                    OP_LDLO: r_d[i] = {r_q[i][WIDTH-1:H], I[H-1:0]};
                    OP_LDHI: r_d[i] = {I[H-1:0], r_q[i][H-1:0]};
                    default: r_d[i] = r_q[i];
                endcase
            end
        end
    end

    // Register bank and wrap pulses; synchronous reset overrides any op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_q[i] <= RESET_VAL;
            end
            wrap_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_q[i] <= r_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

    // Read ports: out-of-range selects return zero, no write bypass.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(OutASel) == i) OutA = r_q[i];
            if (int'(OutBSel) == i) OutB = r_q[i];
        end
    end

    // Zero status straight from register contents.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            ZeroFlag[i] = (r_q[i] == '0);
        end
    end

    assign WrapPulse = wrap_q;

endmodule
